// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: issues reads to instruction memory, presents words to
// decode, pulses the PC increment/load controls and handles taken-branch redirects.
module fetch_unit #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-1:0] pc_in,
  output logic          pc_inc,
  output logic          pc_ld,
  output logic [AW-1:0] pc_ld_val,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [DW-1:0] ir_out,
  output logic [AW-1:0] ir_pc,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic          err
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  typedef enum logic [2:0] {IDLE, REQ, HOLD, FLUSH, REDIR} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [AW-1:0] pend_target;
  logic [CW-1:0] wait_nxt;
  logic          wait_hit;

  // Saturating count of cycles the current read has waited without an ack.
  assign wait_nxt = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + CW'(1);
  assign wait_hit = (wait_nxt == WAIT_LIMIT);

  // NOTE: every register here uses <=, so each branch below reads pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      pend_target <= '0;
      pc_inc      <= 1'b0;
      pc_ld       <= 1'b0;
      pc_ld_val   <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      ir_valid    <= 1'b0;
      ir_out      <= '0;
      ir_pc       <= '0;
      err         <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle; only the arms below raise them.
      pc_inc <= 1'b0;
      pc_ld  <= 1'b0;

      if (br_taken) begin
        pend_target <= br_target;
        ir_valid    <= 1'b0;
        unique case (state)
          IDLE, HOLD, REDIR: begin
            state     <= REDIR;
            pc_ld     <= 1'b1;
            pc_ld_val <= br_target;
          end
          REQ, FLUSH: begin
            if (mem_ack) begin
              // Read completes with the redirect: drop the data, go straight to the load.
              state     <= REDIR;
              mem_req   <= 1'b0;
              pc_ld     <= 1'b1;
              pc_ld_val <= br_target;
            end else begin
              state    <= FLUSH;
              wait_cnt <= wait_nxt;
              if (wait_hit) err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else begin
        unique case (state)
          IDLE: begin
            if (en) begin
              state    <= REQ;
              mem_req  <= 1'b1;
              mem_addr <= pc_in;
              wait_cnt <= '0;
            end
          end
          REQ: begin
            if (mem_ack) begin
              state    <= HOLD;
              ir_out   <= mem_rdata;
              ir_pc    <= mem_addr;
              ir_valid <= 1'b1;
              mem_req  <= 1'b0;
              pc_inc   <= 1'b1;
            end else begin
              wait_cnt <= wait_nxt;
              if (wait_hit) err <= 1'b1;
            end
          end
          HOLD: begin
            if (ir_ready) begin
              state    <= IDLE;
              ir_valid <= 1'b0;
            end
          end
          FLUSH: begin
            if (mem_ack) begin
              state     <= REDIR;
              mem_req   <= 1'b0;
              pc_ld     <= 1'b1;
              pc_ld_val <= pend_target;
            end else begin
              wait_cnt <= wait_nxt;
              if (wait_hit) err <= 1'b1;
            end
          end
          REDIR:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register model, auto-acking memory that pushes expected
// fetches to a scoreboard, and directed scenarios for fetch, stall, branch, flush, timeout, reset.
module tb_fetch_unit;

  localparam int AW       = 16;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 15;

  typedef struct {
    logic [DW-1:0] ir;
    logic [AW-1:0] pc;
  } fetch_t;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [AW-1:0] pc_in;
  logic          pc_inc;
  logic          pc_ld;
  logic [AW-1:0] pc_ld_val;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          ir_valid;
  logic          ir_ready;
  logic [DW-1:0] ir_out;
  logic [AW-1:0] ir_pc;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic          err;

  fetch_unit #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pc_in     (pc_in),
    .pc_inc    (pc_inc),
    .pc_ld     (pc_ld),
    .pc_ld_val (pc_ld_val),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .ir_out    (ir_out),
    .ir_pc     (ir_pc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register the fetch unit drives.
  logic [AW-1:0] pc_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pc_reg <= '0;
    else if (pc_ld)  pc_reg <= pc_ld_val;
    else if (pc_inc) pc_reg <= pc_reg + 16'd1;
  end
  assign pc_in = pc_reg;

  int checks = 0;
  int errors = 0;

  fetch_t        sb[$];
  int            ack_delay;
  bit            drop_next;
  bit            use_force;
  logic [DW-1:0] force_data;

  int            inc_cnt, ld_cnt, valid_cnt, cyc, excl_bad;
  logic          prev_req;
  logic [AW-1:0] req_addrs[$];
  int            req_cyc[$];

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return (a == '0) ? 16'h1234 : (a ^ 16'hC3C3);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory: acks ack_delay negedges after the request is first seen.
  initial begin
    int     cnt;
    fetch_t e;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!rst_n || !mem_req) begin
        cnt = 0;
      end else if (cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = use_force ? force_data : mem_data(mem_addr);
        if (!drop_next) begin
          e.ir = mem_rdata;
          e.pc = mem_addr;
          sb.push_back(e);
        end
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (pc_inc)          inc_cnt++;
    if (pc_ld)           ld_cnt++;
    if (ir_valid)        valid_cnt++;
    if (pc_inc && pc_ld) excl_bad++;
    if (mem_req && !prev_req) begin
      req_addrs.push_back(mem_addr);
      req_cyc.push_back(cyc);
    end
    prev_req = mem_req;
  endtask

  task automatic clear_stats();
    inc_cnt   = 0;
    ld_cnt    = 0;
    valid_cnt = 0;
    req_addrs.delete();
    req_cyc.delete();
  endtask

  task automatic wait_req(input int n, input string tag);
    int k = 0;
    while (req_addrs.size() < n && k < 60) begin
      tick();
      k++;
    end
    if (req_addrs.size() < n) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_fetch(input string tag);
    int     k = 0;
    fetch_t e;
    while (!ir_valid && k < 60) begin
      tick();
      k++;
    end
    if (!ir_valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_ir"}, 32'(ir_out), 32'(e.ir));
    check({tag, "_pc"}, 32'(ir_pc), 32'(e.pc));
  endtask

  task automatic drain(input string tag);
    repeat (4) tick();
    check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int            stable_bad, req_bad, first_err, k;
    logic [DW-1:0] saved_ir;
    logic [AW-1:0] saved_pc;

    rst_n = 1'b0; en = 1'b0; ir_ready = 1'b0; br_taken = 1'b0; br_target = '0;
    ack_delay = 1; drop_next = 1'b0; use_force = 1'b0; force_data = '0;
    cyc = 0; excl_bad = 0; prev_req = 1'b0;
    clear_stats();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ctl", {27'd0, mem_req, ir_valid, err, pc_inc, pc_ld}, 32'd0);
    check("rst_ir", 32'(ir_out), 32'd0);
    check("rst_irpc", 32'(ir_pc), 32'd0);
    check("rst_ldval", 32'(pc_ld_val), 32'd0);
    rst_n = 1'b1;

    // Basic fetch from 0, then sequential next fetch
    clear_stats();
    ir_ready = 1'b1;
    en = 1'b1;
    wait_fetch("t1_f0");
    wait_req(2, "t1_req");
    check("t1_addr0", 32'(req_addrs.size() > 0 ? req_addrs[0] : 'x), 32'h0000);
    check("t1_addr1", 32'(req_addrs.size() > 1 ? req_addrs[1] : 'x), 32'h0001);
    check("t1_inc", inc_cnt, 1);
    check("t1_period", req_cyc.size() > 1 ? req_cyc[1] - req_cyc[0] : -1, 4);
    en = 1'b0;
    wait_fetch("t1_f1");
    drain("t1");

    // Decode stalls for 5 cycles
    clear_stats();
    ir_ready = 1'b0;
    en = 1'b1;
    wait_fetch("t2_f0");
    saved_ir = ir_out;
    saved_pc = ir_pc;
    stable_bad = 0;
    req_bad = 0;
    repeat (5) begin
      tick();
      if (!ir_valid || ir_out !== saved_ir || ir_pc !== saved_pc) stable_bad++;
      if (mem_req) req_bad++;
    end
    check("t2_stable", stable_bad, 0);
    check("t2_noreq", req_bad, 0);
    ir_ready = 1'b1;
    tick();
    check("t2_idle_gap", {ir_valid, mem_req}, 2'b00);
    tick();
    check("t2_refetch", mem_req, 1'b1);
    en = 1'b0;
    wait_fetch("t2_f1");
    drain("t2");

    // Branch while an instruction is held
    ir_ready = 1'b0;
    en = 1'b1;
    wait_fetch("t3_f0");
    clear_stats();
    br_taken  = 1'b1;
    br_target = 16'h03E8;
    tick();
    br_taken = 1'b0;
    check("t3_vdrop", ir_valid, 1'b0);
    check("t3_ld", pc_ld, 1'b1);
    check("t3_ldval", 32'(pc_ld_val), 32'h03E8);
    ir_ready = 1'b1;
    wait_req(1, "t3_req");
    check("t3_addr", 32'(req_addrs.size() > 0 ? req_addrs[0] : 'x), 32'h03E8);
    check("t3_ldcnt", ld_cnt, 1);
    en = 1'b0;
    wait_fetch("t3_f1");
    drain("t3");

    // Branch while a read is outstanding: flushed data never presented
    clear_stats();
    ack_delay  = 3;
    drop_next  = 1'b1;
    use_force  = 1'b1;
    force_data = 16'hBEEF;
    ir_ready   = 1'b1;
    en         = 1'b1;
    wait_req(1, "t4_req0");
    br_taken  = 1'b1;
    br_target = 16'h0100;
    tick();
    br_taken = 1'b0;
    check("t4_req_held", mem_req, 1'b1);
    k = 0;
    while (!pc_ld && k < 20) begin
      tick();
      k++;
    end
    check("t4_ld", pc_ld, 1'b1);
    check("t4_ldval", 32'(pc_ld_val), 32'h0100);
    check("t4_novalid", valid_cnt, 0);
    check("t4_noinc", inc_cnt, 0);
    drop_next = 1'b0;
    use_force = 1'b0;
    ack_delay = 1;
    wait_req(2, "t4_req1");
    check("t4_addr", 32'(req_addrs.size() > 1 ? req_addrs[1] : 'x), 32'h0100);
    en = 1'b0;
    wait_fetch("t4_f1");
    drain("t4");

    // Memory timeout: ERR after MAX_WAIT waiting cycles, sticky afterwards
    clear_stats();
    check("t5_err_pre", err, 1'b0);
    ack_delay = MAX_WAIT + 2;
    en = 1'b1;
    wait_req(1, "t5_req");
    first_err = -1;
    req_bad = 0;
    for (int i = 0; i <= MAX_WAIT + 1; i++) begin
      if (err && first_err < 0) first_err = i;
      if (!mem_req) req_bad++;
      if (i < MAX_WAIT + 1) tick();
    end
    check("t5_err_cycle", first_err, MAX_WAIT);
    check("t5_req_held", req_bad, 0);
    en = 1'b0;
    wait_fetch("t5_f0");
    drain("t5");
    repeat (5) tick();
    check("t5_err_sticky", err, 1'b1);

    // Asynchronous reset in the middle of a request
    clear_stats();
    ack_delay = 10;
    en = 1'b1;
    wait_req(1, "t6_req");
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_async", {29'd0, mem_req, ir_valid, err}, 32'd0);
    check("t6_irpc", 32'(ir_pc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 1;
    clear_stats();
    wait_fetch("t6_f0");
    check("t6_addr", 32'(req_addrs.size() > 0 ? req_addrs[0] : 'x), 32'h0000);
    en = 1'b0;
    drain("t6");

    check("inc_ld_excl", excl_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
